smart_home_zone_ctrl: RTL and testbench

SMART_HOME_ZONE_CTRL -- requirements
Module: smart_home_zone_ctrl

---
 rtl/smart_home_pkg.sv | 21 ++
 rtl/zone_light_timer.sv | 52 +++++
 rtl/smart_home_zone_ctrl.sv | 130 +++++++++++++
 tb/tb_smart_home_zone_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_home_pkg.sv
// smart_home_pkg
// Shared definitions for the smart-home zone controller:
//   - alarm_state_e : alarm FSM encodings (also the alarm_state output code)
//   - DEF_*         : default parameter values used by the controller
package smart_home_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_ENTRY    = 2'b10,
    ST_ALARM    = 2'b11
  } alarm_state_e;

  localparam int DEF_N_ZONES     = 4;
  localparam int DEF_TEMP_W      = 8;
  localparam int DEF_TEMP_ON     = 31;
  localparam int DEF_TEMP_OFF    = 28;
  localparam int DEF_LIGHT_HOLD  = 16;
  localparam int DEF_ENTRY_DELAY = 8;

endpackage

// File: rtl/zone_light_timer.sv
// zone_light_timer
// One light zone: a hold counter that is reloaded by motion in the dark and
// counts down to zero otherwise, plus a manual override forcing the light on.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   motion   : motion detected in this zone
//   bright   : ambient light is bright (1) or dark (0)
//   override : force the light on
//   light    : registered light drive
module zone_light_timer #(
  parameter int LIGHT_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic motion,
  input  logic bright,
  input  logic override,
  output logic light
);

  localparam int HOLD_W = $clog2(LIGHT_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(LIGHT_HOLD);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  function automatic logic [HOLD_W-1:0] sat_dec(input logic [HOLD_W-1:0] v);
    if (v == '0) return v;
    return v - HOLD_W'(1);
  endfunction

  // Bright-room motion neither starts nor extends a hold, but a running hold
  // is not cancelled when the room becomes bright.
  always_comb begin
    if (motion && !bright) cnt_d = HOLD_LD;
    else                   cnt_d = sat_dec(cnt_q);
  end

  // Light decodes the counter value being loaded, so it responds on the same
  // edge that samples the qualifying event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      light <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      light <= (cnt_d != '0) || override;
    end
  end

endmodule

// File: rtl/smart_home_zone_ctrl.sv
// smart_home_zone_ctrl
// Smart-home controller: per-zone motion lights, hysteresis fan control and
// a four-state intrusion alarm with entry delay.
// Ports:
//   clk             : system clock
//   rst             : asynchronous active-high reset
//   motion_sensor   : per-zone motion (1 = motion)
//   light_sensor    : per-zone ambient light (1 = bright)
//   manual_override : per-zone forced light; masks zone motion from the alarm
//   temp_sensor     : shared unsigned temperature sample
//   arm             : level request to arm the alarm
//   disarm_ok       : single-cycle valid disarm pulse
//   light_control   : per-zone light drive
//   fan_control     : fan drive
//   security_alarm  : siren drive (1 only in ALARM)
//   alarm_state     : 00 DISARMED, 01 ARMED, 10 ENTRY, 11 ALARM
module smart_home_zone_ctrl
  import smart_home_pkg::*;
#(
  parameter int N_ZONES     = DEF_N_ZONES,
  parameter int TEMP_W      = DEF_TEMP_W,
  parameter int TEMP_ON     = DEF_TEMP_ON,
  parameter int TEMP_OFF    = DEF_TEMP_OFF,
  parameter int LIGHT_HOLD  = DEF_LIGHT_HOLD,
  parameter int ENTRY_DELAY = DEF_ENTRY_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] motion_sensor,
  input  logic [N_ZONES-1:0] light_sensor,
  input  logic [N_ZONES-1:0] manual_override,
  input  logic [TEMP_W-1:0]  temp_sensor,
  input  logic               arm,
  input  logic               disarm_ok,
  output logic [N_ZONES-1:0] light_control,
  output logic               fan_control,
  output logic               security_alarm,
  output logic [1:0]         alarm_state
);

  localparam logic [TEMP_W-1:0] TEMP_ON_T  = TEMP_W'(TEMP_ON);
  localparam logic [TEMP_W-1:0] TEMP_OFF_T = TEMP_W'(TEMP_OFF);
  localparam int                ENT_W      = $clog2(ENTRY_DELAY + 1);
  localparam logic [ENT_W-1:0]  ENT_LD     = ENT_W'(ENTRY_DELAY);
  localparam logic [ENT_W-1:0]  ENT_ONE    = ENT_W'(1);

  // Zone lights
  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    zone_light_timer #(
      .LIGHT_HOLD(LIGHT_HOLD)
    ) u_zone (
      .clk      (clk),
      .rst      (rst),
      .motion   (motion_sensor[i]),
      .bright   (light_sensor[i]),
      .override (manual_override[i]),
      .light    (light_control[i])
    );
  end

  // Fan hysteresis: between the thresholds the previous drive is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fan_control <= 1'b0;
    end else if (temp_sensor >= TEMP_ON_T) begin
      fan_control <= 1'b1;
    end else if (temp_sensor <= TEMP_OFF_T) begin
      fan_control <= 1'b0;
    end
  end

  // Alarm FSM
  alarm_state_e     state_q, state_d;
  logic [ENT_W-1:0] ent_q, ent_d;
  logic             alarm_d;
  logic             eff_motion;

  // Overridden zones are treated as occupied on purpose and do not trip.
  assign eff_motion  = |(motion_sensor & ~manual_override);
  assign alarm_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_DISARMED;
      ent_q          <= '0;
      security_alarm <= 1'b0;
    end else begin
      state_q        <= state_d;
      ent_q          <= ent_d;
      security_alarm <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ent_d   = '0;
    unique case (state_q)
      ST_DISARMED: begin
        if (arm && !eff_motion) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (eff_motion) begin
          state_d = ST_ENTRY;
          ent_d   = ENT_LD;
        end
      end
      ST_ENTRY: begin
        // arm is ignored here: once the countdown starts only disarm_ok stops it.
        if (ent_q <= ENT_ONE) state_d = ST_ALARM;
        else                  ent_d   = ent_q - ENT_ONE;
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: state_d = ST_DISARMED;
    endcase
    // A valid disarm wins over motion and over countdown expiry.
    if (disarm_ok) begin
      state_d = ST_DISARMED;
      ent_d   = '0;
    end
  end

  always_comb begin
    alarm_d = (state_d == ST_ALARM);
  end

endmodule

// File: tb/tb_smart_home_zone_ctrl.sv
module tb_smart_home_zone_ctrl;

  localparam int NZ   = 4;
  localparam int HOLD = 4;
  localparam int DLY  = 3;
  localparam int TON  = 31;
  localparam int TOFF = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NZ-1:0] motion_sensor = '0;
  logic [NZ-1:0] light_sensor = '0;
  logic [NZ-1:0] manual_override = '0;
  logic [7:0]    temp_sensor = '0;
  logic          arm = 1'b0;
  logic          disarm_ok = 1'b0;
  logic [NZ-1:0] light_control;
  logic          fan_control;
  logic          security_alarm;
  logic [1:0]    alarm_state;

  smart_home_zone_ctrl #(
    .N_ZONES(NZ), .TEMP_W(8), .TEMP_ON(TON), .TEMP_OFF(TOFF),
    .LIGHT_HOLD(HOLD), .ENTRY_DELAY(DLY)
  ) dut (
    .clk(clk), .rst(rst),
    .motion_sensor(motion_sensor), .light_sensor(light_sensor),
    .manual_override(manual_override), .temp_sensor(temp_sensor),
    .arm(arm), .disarm_ok(disarm_ok),
    .light_control(light_control), .fan_control(fan_control),
    .security_alarm(security_alarm), .alarm_state(alarm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lights from "edges since last dark-motion event",
  // alarm from "edges since entry began", fan as a plain hysteresis flag.
  int edge_n = 0;
  int last_ev [NZ];
  int m_state = 0;
  int entry_edge = 0;
  bit m_fan = 0;
  logic [NZ-1:0] m_light = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) last_ev[i] = -1000;
    m_state = 0;
    m_fan   = 0;
    m_light = '0;
  endtask

  task automatic model_edge();
    logic eff;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NZ; i++) begin
      if (motion_sensor[i] && !light_sensor[i]) last_ev[i] = edge_n;
      m_light[i] = manual_override[i] || ((edge_n - last_ev[i]) < HOLD);
    end
    if (int'(temp_sensor) >= TON)       m_fan = 1;
    else if (int'(temp_sensor) <= TOFF) m_fan = 0;
    eff = |(motion_sensor & ~manual_override);
    if (disarm_ok) m_state = 0;
    else begin
      case (m_state)
        0: if (arm && !eff) m_state = 1;
        1: if (!arm) m_state = 0;
           else if (eff) begin m_state = 2; entry_edge = edge_n; end
        2: if (edge_n - entry_edge == DLY) m_state = 3;
        default: m_state = 3;
      endcase
    end
  endtask

  task automatic compare_model();
    chk("light_model", light_control, m_light);
    chk("fan_model", fan_control, m_fan);
    chk("siren_model", security_alarm, (m_state == 3));
    chk("state_model", alarm_state, m_state[1:0]);
  endtask

  // One clock: model and DUT both see the same edge, compare just after it,
  // then return at the falling edge where the next inputs are driven.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_light"}, light_control, 0);
    chk({name, "_fan"}, fan_control, 0);
    chk({name, "_siren"}, security_alarm, 0);
    chk({name, "_state"}, alarm_state, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    // Dark motion in zone 2: on for edges k..k+3, off at k+4
    motion_sensor = 4'b0100;
    tick();
    chk("hold_k", light_control, 4'b0100);
    motion_sensor = '0;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("hold_mid", light_control, 4'b0100);
    end
    tick();
    chk("hold_end", light_control, 4'b0000);
    motion_sensor = 4'b0010;
    light_sensor  = 4'b0010;
    tick();
    chk("bright_motion", light_control, 4'b0000);
    motion_sensor = '0;
    light_sensor  = '0;

    // Fan hysteresis
    begin
      logic [7:0] temps [5];
      logic       fans  [5];
      temps = '{8'd27, 8'd30, 8'd31, 8'd29, 8'd28};
      fans  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int j = 0; j < 5; j++) begin
        temp_sensor = temps[j];
        tick();
        chk("fan_seq", fan_control, fans[j]);
      end
    end

    // Arm, trip, entry delay, alarm, disarm
    arm = 1'b1;
    tick();
    chk("armed", alarm_state, 2'b01);
    motion_sensor = 4'b0001;
    tick();
    chk("entry_k", alarm_state, 2'b10);
    motion_sensor = '0;
    tick();
    chk("entry_k1", alarm_state, 2'b10);
    tick();
    chk("entry_k2", alarm_state, 2'b10);
    chk("siren_pre", security_alarm, 1'b0);
    tick();
    chk("alarm_k3", alarm_state, 2'b11);
    chk("siren_k3", security_alarm, 1'b1);
    tick();
    chk("alarm_hold", alarm_state, 2'b11);
    disarm_ok = 1'b1;
    tick();
    chk("disarmed", alarm_state, 2'b00);
    chk("siren_off", security_alarm, 1'b0);
    disarm_ok = 1'b0;
    tick();
    chk("rearmed", alarm_state, 2'b01);

    // Overridden zone motion does not trip the alarm
    manual_override = 4'b0001;
    motion_sensor   = 4'b0001;
    tick();
    chk("ovr_state", alarm_state, 2'b01);
    chk("ovr_light0", light_control[0], 1'b1);
    manual_override = '0;
    motion_sensor   = '0;

    // disarm_ok on the expiry edge wins
    tick();
    motion_sensor = 4'b0010;
    tick();
    chk("entry2_k", alarm_state, 2'b10);
    motion_sensor = '0;
    tick();
    tick();
    disarm_ok = 1'b1;
    tick();
    chk("race_state", alarm_state, 2'b00);
    chk("race_siren", security_alarm, 1'b0);
    disarm_ok = 1'b0;

    // Asynchronous reset mid-ENTRY and mid-hold
    tick();
    motion_sensor = 4'b1000;
    temp_sensor   = 8'd33;
    tick();
    chk("pre_rst_state", alarm_state, 2'b10);
    chk("pre_rst_light", light_control, 4'b1000);
    chk("pre_rst_fan", fan_control, 1'b1);
    motion_sensor = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clk);
    tick();
    rst = 1'b0;
    temp_sensor = 8'd25;
    tick();
    chk("post_rst", alarm_state, 2'b01);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NZ; i++) begin
        motion_sensor[i]   = ($urandom_range(0, 7) == 0);
        light_sensor[i]    = $urandom_range(0, 1);
        manual_override[i] = ($urandom_range(0, 9) == 0);
      end
      temp_sensor = 8'($urandom_range(24, 35));
      arm         = ($urandom_range(0, 15) != 0);
      disarm_ok   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("rand_rst");
        @(negedge clk);
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
